// File: rtl/i2s_rx_if.sv
// I2S receive-side signal bundle: serial bit clock, word select and data in,
// deserialized left/right samples with their one-cycle strobes out.
interface i2s_rx_if;
    logic        ck;
    logic        ws;
    logic        d;
    logic [15:0] l;
    logic [15:0] r;
    logic        lv;
    logic        rv;

    modport slave (
        input  ck,
        input  ws,
        input  d,
        output l,
        output r,
        output lv,
        output rv
    );

    modport master (
        output ck,
        output ws,
        output d,
        input  l,
        input  r,
        input  lv,
        input  rv
    );
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronizes an external bit clock, word select and data,
// and deserializes 16-bit MSB-first left/right samples with one-cycle strobes.
module i2s_rx #(
    parameter int unsigned SYNC = 2
) (
    input  logic     clock,
    input  logic     reset,
    i2s_rx_if.slave  bus
);

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 5;

    logic [SYNC-1:0] r_ck_sync;
    logic [SYNC-1:0] r_ws_sync;
    logic [SYNC-1:0] r_d_sync;
    logic            r_ck_dly;
    logic [W-1:0]    r_sr;
    logic [CW-1:0]   r_cnt;
    logic            r_wp;
    logic            r_armed;
    logic [W-1:0]    r_l;
    logic [W-1:0]    r_r;
    logic            r_lv;
    logic            r_rv;

    logic            w_rise;
    logic            w_wn;
    logic            w_bit;
    logic            w_room;
    logic [3:0]      w_idx;
    logic [W-1:0]    w_word;

    // ws and d are taken from the same stage as the edge-detected ck
    assign w_rise = r_ck_sync[SYNC-1] & ~r_ck_dly;
    assign w_wn   = r_ws_sync[SYNC-1];
    assign w_bit  = r_d_sync[SYNC-1];
    assign w_room = (r_cnt < CW'(W));
    assign w_idx  = 4'(CW'(W - 1) - r_cnt);

    // Current buffer with this rise's bit dropped into its slot, if one is left
    always_comb begin
        w_word = r_sr;
        if (w_room) begin
            w_word[w_idx] = w_bit;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ck_sync <= '0;
            r_ws_sync <= '0;
            r_d_sync  <= '0;
            r_ck_dly  <= 1'b0;
            r_sr      <= '0;
            r_cnt     <= CW'(W);
            r_wp      <= 1'b0;
            r_armed   <= 1'b0;
            r_l       <= '0;
            r_r       <= '0;
            r_lv      <= 1'b0;
            r_rv      <= 1'b0;
        end else begin
            r_ck_sync <= {r_ck_sync[SYNC-2:0], bus.ck};
            r_ws_sync <= {r_ws_sync[SYNC-2:0], bus.ws};
            r_d_sync  <= {r_d_sync[SYNC-2:0], bus.d};
            r_ck_dly  <= r_ck_sync[SYNC-1];
            r_lv      <= 1'b0;
            r_rv      <= 1'b0;
            if (w_rise) begin
                r_wp <= w_wn;
                if (w_wn != r_wp) begin
                    // Boundary: this bit is the LSB slot of the word for channel wp
                    if (r_armed) begin
                        if (r_wp) begin
                            r_r  <= w_word;
                            r_rv <= 1'b1;
                        end else begin
                            r_l  <= w_word;
                            r_lv <= 1'b1;
                        end
                    end
                    r_sr    <= '0;
                    r_cnt   <= '0;
                    r_armed <= 1'b1;
                end else if (w_room) begin
                    r_sr  <= w_word;
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.l  = r_l;
    assign bus.r  = r_r;
    assign bus.lv = r_lv;
    assign bus.rv = r_rv;

endmodule
